shift_seq_ctrl: RTL and testbench

//  Multi-bit shift sequencer for the bc6502 16-bit datapath. Accepts one shift/rotate command
//  (ASL/ROL/LSR/ROR, 8- or 16-bit, count 0..2^CNTW-1), then drives the one-bit shiftUnit once
//  per clock. Rotates go through carry. Returns the result and N/Z/C flags with a done pulse.

---
 rtl/shift_seq_pkg.sv | 20 ++
 rtl/shift_seq_ctrl_shift_unit.sv | 37 +++
 rtl/shift_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding, op codes, default widths.
package shift_seq_pkg;

   localparam int DBW_DEF  = 16;
   localparam int CNTW_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_ASL = 2'd0,
      OP_ROL = 2'd1,
      OP_LSR = 2'd2,
      OP_ROR = 2'd3
   } op_e;

endpackage

// File: rtl/shift_seq_ctrl_shift_unit.sv
// shiftUnit: one-bit shift/rotate step for the 16-bit datapath; 8-bit mode works on bits 7:0.
module shiftUnit
   import shift_seq_pkg::*;
#(
   parameter int DBW = DBW_DEF
) (
   input  logic           sz_i,
   input  logic [1:0]     op_i,
   input  logic           ci_i,
   input  logic [DBW-1:0] a_i,
   output logic [DBW-1:0] o_o,
   output logic           co_o
);

   always_comb begin
      o_o  = a_i;
      co_o = ci_i;
      if (sz_i) begin
         case (op_e'(op_i))
            OP_ASL: begin o_o[7:0] = {a_i[6:0], 1'b0}; co_o = a_i[7]; end
            OP_ROL: begin o_o[7:0] = {a_i[6:0], ci_i}; co_o = a_i[7]; end
            OP_LSR: begin o_o[7:0] = {1'b0, a_i[7:1]}; co_o = a_i[0]; end
            OP_ROR: begin o_o[7:0] = {ci_i, a_i[7:1]}; co_o = a_i[0]; end
            default: ;
         endcase
      end else begin
         case (op_e'(op_i))
            OP_ASL: begin o_o = {a_i[DBW-2:0], 1'b0}; co_o = a_i[DBW-1]; end
            OP_ROL: begin o_o = {a_i[DBW-2:0], ci_i}; co_o = a_i[DBW-1]; end
            OP_LSR: begin o_o = {1'b0, a_i[DBW-1:1]}; co_o = a_i[0]; end
            OP_ROR: begin o_o = {ci_i, a_i[DBW-1:1]}; co_o = a_i[0]; end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift sequencer driving shiftUnit one step per clock.
// Optional sticky overflow flag v_o when SHIFT_SEQ_OVF_EN is defined; otherwise v_o is 0.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int DBW  = DBW_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            sz_i,
   input  logic [1:0]      op_i,
   input  logic [CNTW-1:0] cnt_i,
   input  logic            ci_i,
   input  logic [DBW-1:0]  a_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [DBW-1:0]  res_o,
   output logic            c_o,
   output logic            n_o,
   output logic            z_o,
   output logic            v_o
);

   function automatic logic f_neg(input logic sz, input logic [DBW-1:0] r);
      return sz ? r[7] : r[DBW-1];
   endfunction

   function automatic logic f_zero(input logic sz, input logic [DBW-1:0] r);
      return sz ? (r[7:0] == 8'd0) : (r == '0);
   endfunction

   state_e          state_q, state_d;
   logic            sz_q, sz_d;
   logic [1:0]      op_q, op_d;
   logic            carry_q, carry_d;
   logic [DBW-1:0]  acc_q, acc_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [DBW-1:0]  res_q, res_d;
   logic            c_q, c_d, n_q, n_d, z_q, z_d;

   logic [DBW-1:0]  step_o;
   logic            step_co;
   logic [DBW-1:0]  step_res;
   logic            accept;

   shiftUnit #(.DBW(DBW)) u_shift (
      .sz_i (sz_q),
      .op_i (op_q),
      .ci_i (carry_q),
      .a_i  (acc_q),
      .o_o  (step_o),
      .co_o (step_co)
   );

   // Upper byte is restored from acc in 8-bit mode, whatever the unit drives there.
   assign step_res = sz_q ? {acc_q[DBW-1:8], step_o[7:0]} : step_o;
   assign accept   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_comb begin
      state_d = state_q;
      sz_d    = sz_q;
      op_d    = op_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      count_d = count_q;
      res_d   = res_q;
      c_d     = c_q;
      n_d     = n_q;
      z_d     = z_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               sz_d    = sz_i;
               op_d    = op_i;
               carry_d = ci_i;
               acc_d   = a_i;
               count_d = cnt_i;
               if (cnt_i == '0) begin
                  state_d = ST_DONE;
                  res_d   = a_i;
                  c_d     = ci_i;
                  n_d     = f_neg(sz_i, a_i);
                  z_d     = f_zero(sz_i, a_i);
               end else begin
                  state_d = ST_SHIFT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            acc_d   = step_res;
            carry_d = step_co;
            count_d = count_q - CNTW'(1);
            if (count_q == CNTW'(1)) begin
               state_d = ST_DONE;
               res_d   = step_res;
               c_d     = step_co;
               n_d     = f_neg(sz_q, step_res);
               z_d     = f_zero(sz_q, step_res);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sz_q    <= 1'b0;
         op_q    <= 2'd0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         count_q <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         sz_q    <= sz_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         res_q   <= res_d;
         c_q     <= c_d;
         n_q     <= n_d;
         z_q     <= z_d;
      end
   end

`ifdef SHIFT_SEQ_OVF_EN
   logic v_q, v_d;
   logic sign_flip, left_op;

   assign sign_flip = sz_q ? (step_o[7] ^ acc_q[7]) : (step_o[DBW-1] ^ acc_q[DBW-1]);
   assign left_op   = (op_e'(op_q) == OP_ASL) || (op_e'(op_q) == OP_ROL);

   always_comb begin
      v_d = v_q;
      if (accept)
         v_d = 1'b0;
      else if ((state_q == ST_SHIFT) && left_op && sign_flip)
         v_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) v_q <= 1'b0;
      else     v_q <= v_d;
   end

   assign v_o = v_q;
`else
   assign v_o = 1'b0;
`endif

   assign busy_o = (state_q == ST_SHIFT);
   assign done_o = (state_q == ST_DONE);
   assign res_o  = res_q;
   assign c_o    = c_q;
   assign n_o    = n_q;
   assign z_o    = z_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized commands vs. a ring model.
module tb_shift_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sz;
   logic [1:0]  op;
   logic [4:0]  cnt;
   logic        ci;
   logic [15:0] a;
   logic        busy, done;
   logic [15:0] res;
   logic        c, n, z, v;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.DBW(16), .CNTW(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .sz_i    (sz),
      .op_i    (op),
      .cnt_i   (cnt),
      .ci_i    (ci),
      .a_i     (a),
      .busy_o  (busy),
      .done_o  (done),
      .res_o   (res),
      .c_o     (c),
      .n_o     (n),
      .z_o     (z),
      .v_o     (v)
   );

`ifdef SHIFT_SEQ_OVF_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   // Whole-command model: shifts as plain arithmetic, rotates as a (w+1)-bit ring {carry, value}.
   function automatic void model(input bit szm, input bit [1:0] opm, input int k, input bit cim,
                                 input bit [15:0] am, output bit [15:0] r, output bit cm,
                                 output bit nm, output bit zm, output bit vm);
      int w, m;
      longint mask, rmask, val, ring, outr, outv, t;
      w     = szm ? 8 : 16;
      mask  = (64'd1 << w) - 1;
      rmask = (64'd1 << (w + 1)) - 1;
      val   = longint'(am) & mask;
      ring  = (longint'(cim) << w) | val;
      m     = k % (w + 1);
      vm    = 1'b0;
      outv  = val;
      cm    = cim;
      case (opm)
         2'd0: begin
            outv = (val << k) & mask;
            if (k != 0) cm = (((val << k) >> w) & 1) != 0;
            for (int i = 0; i < k; i++) begin
               t = (val << i) & mask;
               if (((t >> (w - 1)) & 1) != ((t >> (w - 2)) & 1)) vm = 1'b1;
            end
         end
         2'd1: begin
            outr = ((ring << m) | (ring >> (w + 1 - m))) & rmask;
            cm   = ((outr >> w) & 1) != 0;
            outv = outr & mask;
            for (int i = 0; i < k; i++) begin
               int s;
               s = i % (w + 1);
               t = ((ring << s) | (ring >> (w + 1 - s))) & mask;
               if (((t >> (w - 1)) & 1) != ((t >> (w - 2)) & 1)) vm = 1'b1;
            end
         end
         2'd2: begin
            outv = val >> k;
            if (k != 0) cm = ((val >> (k - 1)) & 1) != 0;
         end
         default: begin
            outr = ((ring >> m) | (ring << (w + 1 - m))) & rmask;
            cm   = ((outr >> w) & 1) != 0;
            outv = outr & mask;
         end
      endcase
      r  = szm ? {am[15:8], outv[7:0]} : outv[15:0];
      nm = szm ? r[7] : r[15];
      zm = szm ? (r[7:0] == 8'd0) : (r == 16'd0);
      if (!OVF) vm = 1'b0;
   endfunction

   // Issue one command and count negedges until done (capped at 40).
   task automatic run_cmd(input bit s, input bit [1:0] o, input bit [4:0] k, input bit cin,
                          input bit [15:0] av, output int lat, output bit busy_gap);
      @(negedge clk);
      sz = s; op = o; cnt = k; ci = cin; a = av; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      busy_gap = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (done) break;
         if (!busy) busy_gap = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; sz = 1'b0; op = 2'd0; cnt = 5'd3; ci = 1'b1; a = 16'hFFFF;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, res, c, n, z, v} !== 21'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {busy, done, res, c, n, z, v});
      end
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      int lat; bit gap;
      run_cmd(1'b0, 2'd0, 5'd1, 1'b0, 16'h8001, lat, gap);
      total++;
      if ({res, c, n, z} !== {16'h0002, 3'b100} || lat != 2) begin
         bad++;
         $display("FAIL asl16 got res=%h cnz=%b%b%b lat=%0d want res=0002 cnz=100 lat=2", res, c, n, z, lat);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL done_width got=%b want=0", done);
      end
      run_cmd(1'b1, 2'd1, 5'd2, 1'b1, 16'h1280, lat, gap);
      total++;
      if ({res, c, n, z} !== {16'h1203, 3'b000} || lat != 3 || gap) begin
         bad++;
         $display("FAIL rol8 got res=%h cnz=%b%b%b lat=%0d gap=%b want res=1203 cnz=000 lat=3", res, c, n, z, lat, gap);
      end
      run_cmd(1'b0, 2'd2, 5'd0, 1'b1, 16'h0001, lat, gap);
      total++;
      if ({res, c, n, z} !== {16'h0001, 3'b100} || lat != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL lsr_cnt0 got res=%h cnz=%b%b%b lat=%0d busy=%b want res=0001 cnz=100 lat=1 busy=0", res, c, n, z, lat, busy);
      end
   endtask

   task automatic test_ignore_and_back_to_back();
      int lat; bit gap;
      @(negedge clk);
      sz = 1'b0; op = 2'd3; cnt = 5'd17; ci = 1'b0; a = 16'h0001; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (done) break;
         if (lat == 4) begin
            start = 1'b1; op = 2'd0; a = 16'hFFFF; cnt = 5'd1;
         end
         if (lat == 5) start = 1'b0;
      end
      total++;
      if ({res, c} !== {16'h0001, 1'b0} || lat != 18) begin
         bad++;
         $display("FAIL ror17_ignore got res=%h c=%b lat=%0d want res=0001 c=0 lat=18", res, c, lat);
      end
      sz = 1'b0; op = 2'd0; cnt = 5'd3; ci = 1'b0; a = 16'h0001; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      gap = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (done) break;
         if (!busy) gap = 1'b1;
      end
      total++;
      if ({res, c} !== {16'h0008, 1'b0} || lat != 4 || gap) begin
         bad++;
         $display("FAIL back_to_back got res=%h c=%b lat=%0d gap=%b want res=0008 c=0 lat=4", res, c, lat, gap);
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat, dones; bit gap;
      bit [15:0] er; bit ec, en, ez, ev;
      @(negedge clk);
      sz = 1'b0; op = 2'd1; cnt = 5'd10; ci = 1'b1; a = 16'hA5C3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({busy, done, res, c, n, z, v} !== 21'd0) begin
         bad++;
         $display("FAIL reset_mid got=%h want=0", {busy, done, res, c, n, z, v});
      end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL reset_no_done got=%0d want=0", dones);
      end
      model(1'b0, 2'd3, 5, 1'b1, 16'h1234, er, ec, en, ez, ev);
      run_cmd(1'b0, 2'd3, 5'd5, 1'b1, 16'h1234, lat, gap);
      total++;
      if ({res, c, n, z} !== {er, ec, en, ez} || lat != 6) begin
         bad++;
         $display("FAIL after_reset got res=%h c=%b lat=%0d want res=%h c=%b lat=6", res, c, lat, er, ec);
      end
   endtask

   task automatic test_ovf();
      int lat; bit gap;
      run_cmd(1'b0, 2'd0, 5'd1, 1'b0, 16'h4000, lat, gap);
      total++;
      if ({res, n, v} !== {16'h8000, 1'b1, OVF}) begin
         bad++;
         $display("FAIL ovf_set got res=%h n=%b v=%b want res=8000 n=1 v=%b", res, n, v, OVF);
      end
      run_cmd(1'b0, 2'd0, 5'd2, 1'b0, 16'h0001, lat, gap);
      total++;
      if ({res, v} !== {16'h0004, 1'b0}) begin
         bad++;
         $display("FAIL ovf_clear got res=%h v=%b want res=0004 v=0", res, v);
      end
   endtask

   task automatic test_random();
      int lat; bit gap;
      bit s, cin; bit [1:0] o; bit [4:0] k; bit [15:0] av;
      bit [15:0] er; bit ec, en, ez, ev;
      for (int i = 0; i < 60; i++) begin
         s   = 1'($urandom_range(0, 1));
         o   = 2'($urandom_range(0, 3));
         k   = 5'($urandom_range(0, 31));
         cin = 1'($urandom_range(0, 1));
         av  = 16'($urandom);
         if (i == 0) begin s = 1'b1; o = 2'd1; k = 5'd9; end
         if (i == 1) begin s = 1'b0; o = 2'd3; k = 5'd17; end
         model(s, o, int'(k), cin, av, er, ec, en, ez, ev);
         run_cmd(s, o, k, cin, av, lat, gap);
         total++;
         if ({res, c, n, z, v} !== {er, ec, en, ez, ev} || lat != int'(k) + 1 || gap) begin
            bad++;
            $display("FAIL rand%0d sz=%b op=%0d cnt=%0d ci=%b a=%h got res=%h cnzv=%b%b%b%b lat=%0d want res=%h cnzv=%b%b%b%b lat=%0d",
                     i, s, o, k, cin, av, res, c, n, z, v, lat, er, ec, en, ez, ev, int'(k) + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_and_back_to_back();
      test_reset_mid_shift();
      test_ovf();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
